// File: rtl/uart_fifo_io.sv
`timescale 1ns/1ps
// Memory-mapped full-duplex 8N1 UART with TX/RX FIFOs and sticky error flags.
// Bus handshake: a write is taken on any edge with io_sel & mem_wstrb, a read on io_sel & mem_rstrb; mem_rdata is valid the cycle after the read strobe and holds until the next read.
module uart_fifo_io #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD_RATE   = 115200,
  parameter int TX_DEPTH    = 8,
  parameter int RX_DEPTH    = 8,
  parameter int DAT_bit     = 1,
  parameter int CNTL_bit    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_sel,
  input  logic [29:0] mem_wordaddr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_wstrb,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  input  logic        RXD,
  output logic        TXD,
  output logic [1:0]  dbg_tx_state_o,
  output logic [2:0]  dbg_rx_state_o
);

  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW  = $clog2(DIV);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;

  logic rd_en, wr_en, wr_dat, wr_ctl;
  assign wr_en  = io_sel & mem_wstrb;
  assign rd_en  = io_sel & mem_rstrb;
  assign wr_dat = wr_en & mem_wordaddr[DAT_bit];
  assign wr_ctl = wr_en & mem_wordaddr[CNTL_bit];

  logic unused_bits;
  assign unused_bits = ^{mem_wdata, mem_wordaddr};

  // ---------------- TX FIFO ----------------
  logic [7:0]     tx_mem_q [TX_DEPTH];
  logic [TAW-1:0] tx_wp_q, tx_rp_q;
  logic [TAW:0]   tx_cnt_q;
  logic           tx_full, tx_empty, tx_push, tx_pop;
  assign tx_full  = (tx_cnt_q == (TAW+1)'(TX_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_push  = wr_dat & ~tx_full;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= mem_wdata[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + TAW'(1);
      if (tx_pop)  tx_rp_q <= tx_rp_q + TAW'(1);
      if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + (TAW+1)'(1);
      else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - (TAW+1)'(1);
    end
  end

  // ---------------- TX shifter ----------------
  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_baud_q, tx_baud_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          txd_q, txd_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      txd_q      <= txd_d;
    end
  end

  // TXD is registered alongside the state so each bit lasts exactly DIV clocks.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_sh_d    = tx_mem_q[tx_rp_q];
          txd_d      = 1'b0;
          tx_baud_d  = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_baud_q == DIV_M1) begin
          tx_baud_d  = '0;
          tx_bit_d   = '0;
          txd_d      = tx_sh_q[0];
          tx_state_d = TX_DATA;
        end else tx_baud_d = tx_baud_q + CW'(1);
      end
      TX_DATA: begin
        if (tx_baud_q == DIV_M1) begin
          tx_baud_d = '0;
          if (tx_bit_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            txd_d    = tx_sh_q[1];
          end
        end else tx_baud_d = tx_baud_q + CW'(1);
      end
      TX_STOP: begin
        if (tx_baud_q == DIV_M1) begin
          tx_baud_d = '0;
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_sh_d    = tx_mem_q[tx_rp_q];
            txd_d      = 1'b0;
            tx_state_d = TX_START;
          end else tx_state_d = TX_IDLE;
        end else tx_baud_d = tx_baud_q + CW'(1);
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // ---------------- RX path ----------------
  logic          rx_s1_q, rx_s2_q;
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_baud_q, rx_baud_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_push, ovr_set, frm_set;

  logic [7:0]     rx_mem_q [RX_DEPTH];
  logic [RAW-1:0] rx_wp_q, rx_rp_q;
  logic [RAW:0]   rx_cnt_q;
  logic           rx_full, rx_empty, rx_pop;
  assign rx_full  = (rx_cnt_q == (RAW+1)'(RX_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_pop   = rd_en & mem_wordaddr[DAT_bit] & ~rx_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_s1_q    <= RXD;
      rx_s2_q    <= rx_s1_q;
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
    end
  end

  // A low stop bit parks in RX_BREAK so a held-low line cannot restart a frame.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_push    = 1'b0;
    ovr_set    = 1'b0;
    frm_set    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s2_q) begin
          rx_baud_d  = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_baud_q == HALF_M1) begin
          rx_baud_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else rx_baud_d = rx_baud_q + CW'(1);
      end
      RX_DATA: begin
        if (rx_baud_q == DIV_M1) begin
          rx_baud_d = '0;
          rx_sh_d   = {rx_s2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else rx_bit_d = rx_bit_q + 3'd1;
        end else rx_baud_d = rx_baud_q + CW'(1);
      end
      RX_STOP: begin
        if (rx_baud_q == DIV_M1) begin
          rx_baud_d = '0;
          if (rx_s2_q) begin
            if (rx_full) ovr_set = 1'b1;
            else rx_push = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            frm_set    = 1'b1;
            rx_state_d = RX_BREAK;
          end
        end else rx_baud_d = rx_baud_q + CW'(1);
      end
      RX_BREAK: if (rx_s2_q) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wp_q] <= rx_sh_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (rx_push) rx_wp_q <= rx_wp_q + RAW'(1);
      if (rx_pop)  rx_rp_q <= rx_rp_q + RAW'(1);
      if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + (RAW+1)'(1);
      else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - (RAW+1)'(1);
    end
  end

  // ---------------- flags and register read ----------------
  logic        ovr_q, ovr_d, frm_q, frm_d, tx_idle;
  logic [31:0] status, rd_word, rdata_q, rdata_d;

  // A hardware set wins over a software clear in the same cycle.
  assign ovr_d   = ovr_set | (ovr_q & ~(wr_ctl & mem_wdata[11]));
  assign frm_d   = frm_set | (frm_q & ~(wr_ctl & mem_wdata[12]));
  assign tx_idle = tx_empty & (tx_state_q == TX_IDLE);
  assign status  = {19'b0, frm_q, ovr_q, tx_idle, tx_full, ~rx_empty, 8'b0};

  always_comb begin
    rd_word = '0;
    if (mem_wordaddr[DAT_bit] && !rx_empty) rd_word = rd_word | {24'b0, rx_mem_q[rx_rp_q]};
    if (mem_wordaddr[CNTL_bit])             rd_word = rd_word | status;
  end
  assign rdata_d = rd_en ? rd_word : rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovr_q   <= 1'b0;
      frm_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ovr_q   <= ovr_d;
      frm_q   <= frm_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_rdata      = rdata_q;
  assign TXD            = txd_q;
  assign dbg_tx_state_o = tx_state_q;
  assign dbg_rx_state_o = rx_state_q;

endmodule

// File: tb/tb_uart_fifo_io.sv
`timescale 1ns/1ps
// Bench for uart_fifo_io: bus/serial drivers, a timing-level reference model,
// and decoupled monitors for read data and TX frames.
module tb_uart_fifo_io;

  localparam int DIV   = 10;
  localparam int FRAME = 10 * DIV;
  localparam int DEPTH = 8;
  localparam logic [29:0] A_DAT = 30'h2;
  localparam logic [29:0] A_CTL = 30'h4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        io_sel = 1'b0;
  logic [29:0] mem_wordaddr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_wstrb = 1'b0;
  logic        mem_rstrb = 1'b0;
  logic [31:0] mem_rdata;
  logic        RXD = 1'b1;
  logic        TXD;
  logic [1:0]  dbg_tx_unused;
  logic [2:0]  dbg_rx_unused;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_fifo_io #(
    .CLK_FREQ_HZ(1000000), .BAUD_RATE(100000), .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH),
    .DAT_bit(1), .CNTL_bit(2)
  ) dut (
    .clk(clk), .reset(reset), .io_sel(io_sel), .mem_wordaddr(mem_wordaddr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rstrb(mem_rstrb),
    .mem_rdata(mem_rdata), .RXD(RXD), .TXD(TXD),
    .dbg_tx_state_o(dbg_tx_unused), .dbg_rx_state_o(dbg_rx_unused)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // TX: each accepted byte gets a frame start edge; a frame owns FRAME clocks.
  int          tx_starts[$];
  logic [39:0] tx_exp_q[$];     // {start edge, byte}
  logic [7:0]  model_rx[$];
  bit          m_ovr = 0, m_frm = 0;
  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];

  function automatic int tx_occ(input int r);
    int n = 0;
    foreach (tx_starts[i]) if (tx_starts[i] >= r) n++;
    return n;
  endfunction

  function automatic bit tx_busy(input int r);
    foreach (tx_starts[i]) if (tx_starts[i] <= r - 1 && r - 1 < tx_starts[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_status(input int r);
    logic [31:0] st = '0;
    st[8]  = (model_rx.size() != 0);
    st[9]  = (tx_occ(r) == DEPTH);
    st[10] = (tx_occ(r) == 0) && !tx_busy(r);
    st[11] = m_ovr;
    st[12] = m_frm;
    return st;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [29:0] a, input logic [31:0] d);
    int w, s;
    @(negedge clk);
    io_sel = 1'b1; mem_wordaddr = a; mem_wdata = d; mem_wstrb = 1'b1; mem_rstrb = 1'b0;
    w = cyc + 1;
    if (a[1] && tx_occ(w) < DEPTH) begin
      s = w + 1;
      if (tx_starts.size() != 0 && tx_starts[$] + FRAME > s) s = tx_starts[$] + FRAME;
      tx_starts.push_back(s);
      tx_exp_q.push_back({32'(s), d[7:0]});
    end
    if (a[2]) begin
      if (d[11]) m_ovr = 0;
      if (d[12]) m_frm = 0;
    end
  endtask

  task automatic bus_read(input logic [29:0] a, input string name);
    logic [31:0] e = '0;
    @(negedge clk);
    io_sel = 1'b1; mem_wordaddr = a; mem_rstrb = 1'b1; mem_wstrb = 1'b0;
    if (a[2]) e = e | model_status(cyc + 1);
    if (a[1] && model_rx.size() != 0) e = e | {24'b0, model_rx.pop_front()};
    rd_exp_q.push_back(e);
    rd_name_q.push_back(name);
  endtask

  task automatic bus_idle();
    @(negedge clk);
    io_sel = 1'b0; mem_wstrb = 1'b0; mem_rstrb = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_v);
    logic [9:0] fr;
    fr = {stop_v, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      RXD = fr[i];
      repeat (DIV - 1) @(negedge clk);
    end
    @(negedge clk);
    RXD = 1'b1;
    if (stop_v) begin
      if (model_rx.size() < DEPTH) model_rx.push_back(b);
      else m_ovr = 1;
    end else m_frm = 1;
    repeat (4) @(negedge clk);
  endtask

  // ---------------- read-data monitor ----------------
  logic rd_pend = 1'b0;
  always @(posedge clk) rd_pend <= io_sel & mem_rstrb & ~reset;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd_unexpected actual=0x%0h expected=none", mem_rdata);
      end else check(rd_name_q.pop_front(), mem_rdata, rd_exp_q.pop_front());
    end
  end

  // ---------------- TX line monitor ----------------
  bit         tm_active = 0;
  int         tm_idx, tm_start, tm_exp_start, tm_bad;
  logic [7:0] tm_byte;
  logic       tm_prev = 1'b1;

  always @(negedge clk) begin
    logic [39:0] ent;
    logic eb;
    if (reset) begin
      tm_active = 0;
      tm_prev   = 1'b1;
    end else begin
      if (!tm_active) begin
        if (tm_prev && !TXD) begin
          tm_active = 1; tm_idx = 1; tm_bad = 0; tm_start = cyc;
          if (tx_exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL tx_unexpected actual=frame_start@%0d expected=idle_line", cyc);
            tm_byte = '0; tm_exp_start = cyc;
          end else begin
            ent = tx_exp_q.pop_front();
            tm_byte = ent[7:0];
            tm_exp_start = int'(ent[39:8]);
          end
        end
      end else begin
        if (tm_idx < DIV) eb = 1'b0;
        else if (tm_idx < 9 * DIV) eb = tm_byte[tm_idx / DIV - 1];
        else eb = 1'b1;
        if (TXD !== eb) tm_bad++;
        tm_idx++;
        if (tm_idx == FRAME) begin
          tm_active = 0;
          checks++;
          if (tm_bad != 0 || tm_start != tm_exp_start) begin
            failures++;
            $display("FAIL tx_frame byte=0x%02h actual start=%0d bad_samples=%0d expected start=%0d bad_samples=0",
                     tm_byte, tm_start, tm_bad, tm_exp_start);
          end
        end
      end
      tm_prev = TXD;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    logic [1:0] cl;
    int last, n;

    repeat (3) @(negedge clk);
    check("reset_txd", TXD, 1);
    check("reset_rdata", mem_rdata, 0);
    reset = 1'b0;
    bus_read(A_CTL, "reset_status"); bus_idle();

    // single frame
    bus_write(A_DAT, 32'h41); bus_idle();
    repeat (FRAME + 5) @(negedge clk);
    bus_read(A_CTL, "t1_idle"); bus_idle();

    // back-to-back burst filling the FIFO, then one dropped write
    for (int i = 0; i < 9; i++) bus_write(A_DAT, 32'h30 + i);
    bus_read(A_CTL, "t2_full");
    bus_write(A_DAT, 32'h39);
    bus_read(A_CTL, "t2_full_after_drop"); bus_idle();
    repeat (9 * FRAME + 20) @(negedge clk);
    bus_read(A_CTL, "t2_drained"); bus_idle();

    // single RX frame
    send_rx(8'h5A, 1'b1);
    bus_read(A_CTL, "t3_rx_ready");
    bus_read(A_DAT, "t3_data");
    bus_read(A_CTL, "t3_rx_empty"); bus_idle();

    // overrun
    for (int i = 0; i < 9; i++) send_rx(8'($urandom), 1'b1);
    bus_read(A_CTL, "t4_overrun");
    bus_write(A_CTL, 32'h800);
    bus_read(A_CTL, "t4_ovr_cleared");
    for (int i = 0; i < 8; i++) bus_read(A_DAT, "t4_data");
    bus_read(A_DAT, "t4_empty_data"); bus_idle();

    // framing error and a short glitch
    send_rx(8'($urandom), 1'b0);
    bus_read(A_CTL, "t5_framing"); bus_idle();
    @(negedge clk); RXD = 1'b0;
    repeat (3) @(negedge clk); RXD = 1'b1;
    repeat (20) @(negedge clk);
    bus_read(A_CTL, "t5_glitch");
    bus_read(A_DAT | A_CTL, "t5_both_empty"); bus_idle();

    // randomized mix
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 6))
        0: begin
          n = $urandom_range(1, 4);
          for (int j = 0; j < n; j++) bus_write(A_DAT, {24'b0, 8'($urandom)});
          bus_idle();
        end
        1: begin bus_read(A_CTL, "rnd_status"); bus_idle(); end
        2: send_rx(8'($urandom), 1'b1);
        3: begin bus_read(A_DAT, "rnd_data"); bus_idle(); end
        4: repeat ($urandom_range(1, 150)) @(negedge clk);
        5: begin bus_read(A_DAT | A_CTL, "rnd_both"); bus_idle(); end
        default: begin
          cl = 2'($urandom_range(0, 3));
          bus_write(A_CTL, {19'b0, cl, 11'b0});
          bus_read(A_CTL, "rnd_clear"); bus_idle();
        end
      endcase
    end

    last = (tx_starts.size() != 0) ? tx_starts[$] + FRAME : 0;
    while (cyc < last + 5) @(negedge clk);
    bus_read(A_CTL, "rnd_final_status"); bus_idle();
    @(negedge clk);
    check("tx_exp_drained", tx_exp_q.size(), 0);
    check("rd_exp_drained", rd_exp_q.size(), 0);

    // reset during TX data and RX frame
    for (int i = 0; i < 9; i++) bus_read(A_DAT, "t6_drain");
    bus_idle();
    send_rx(8'hA5, 1'b1);
    bus_read(A_DAT, "t6_pre_data"); bus_idle();
    bus_write(A_DAT, 32'h00); bus_idle();
    repeat (35) @(negedge clk);
    RXD = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6_txd_async", TXD, 1);
    check("t6_rdata_async", mem_rdata, 0);
    RXD = 1'b1;
    repeat (2) @(negedge clk);
    tx_starts.delete(); tx_exp_q.delete(); model_rx.delete();
    m_ovr = 0; m_frm = 0;
    reset = 1'b0;
    check("t6_txd_after", TXD, 1);
    bus_read(A_CTL, "t6_post_status"); bus_idle();
    repeat (FRAME) @(negedge clk);
    check("t6_no_tx", tx_exp_q.size(), 0);
    check("t6_rd_drained", rd_exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_fifo_io.md
Name: uart_fifo_io

Overview:
Memory-mapped full-duplex 8N1 UART for the SOC IO page.
- Replaces the transmit-only emitter plus the inline status decode in the SOC.
- Adds parametrised TX/RX FIFOs, a receiver, and sticky error flags.
- Sits on the processor bus beside RAM, selected by the SOC's IO-page decode.
- Keeps the existing status bit 9 "busy" semantics, so current putc loops work unchanged.

Parameters:
CLK_FREQ_HZ, 50000000, system clock frequency.
BAUD_RATE, 115200, line rate; DIV = CLK_FREQ_HZ/BAUD_RATE (integer, ≥4) clocks per bit.
TX_DEPTH, 8, TX FIFO entries (power of two, ≥2).
RX_DEPTH, 8, RX FIFO entries (power of two, ≥2).
DAT_bit, 1, word-address bit selecting the DATA register (one-hot IO addressing).
CNTL_bit, 2, word-address bit selecting the CNTL/status register.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
io_sel  in  1  IO page selected (SOC isIO).
mem_wordaddr  in  30  word address mem_addr[31:2].
mem_wdata  in  32  write data.
mem_wstrb  in  1  write strobe (any wmask bit set).
mem_rstrb  in  1  read strobe.
mem_rdata  out  32  registered read data.
RXD  in  1  serial input, asynchronous.
TXD  out  1  serial output.

Behaviour:
- Interface: one clock `clk`; reset is asynchronous and active-high (`reset`). All state is in the clk domain.
- Reset values:
  - TXD=1, mem_rdata=0.
  - Both FIFOs empty.
  - Overrun and framing flags 0.
  - TX FSM=IDLE, RX FSM=IDLE.
  - RX synchroniser stages =1.
- Reset mid-frame aborts the frame; TXD returns high immediately, via its async clear.
- Register access:
  - Writes are active when io_sel & mem_wstrb. Reads are active when io_sel & mem_rstrb.
  - Write DATA: push mem_wdata[7:0] into the TX FIFO. If the TX FIFO is full, drop the byte silently. There is no stall.
  - Write CNTL: bit 11=1 clears the overrun flag; bit 12=1 clears the framing flag. Other bits are ignored.
  - Read latency is 1 cycle: mem_rdata is updated on the strobe edge and held until the next read.
  - Read DATA: if the RX FIFO is non-empty, return {24'b0, head} and pop on the same edge; otherwise return 0 and do not pop.
  - Read CNTL returns the status word:
    - bit 8: RX FIFO non-empty.
    - bit 9: TX FIFO full (busy).
    - bit 10: TX idle (FIFO empty and shifter IDLE).
    - bit 11: overrun.
    - bit 12: framing error.
    - All other bits are 0.
  - If both address bits are set, the result is the OR of both values, and the pop rule still applies.
- FIFOs:
  - Circular buffers with read/write pointers and an occupancy count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
  - A simultaneous push and pop on a full or empty FIFO is legal; the count stays consistent.
  - A push when full is dropped. A pop when empty never occurs.
- TX FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: when the TX FIFO is non-empty, pop one byte into the shifter and enter START. TXD=0 for DIV clocks.
  - DATA: 8 bits LSB first, DIV clocks each.
  - STOP: TXD=1 for DIV clocks.
  - Back-to-back frames have no extra idle gap: the next pop happens in the cycle STOP completes.
- RX path:
  - RXD passes through a 2-FF synchroniser.
  - IDLE: a synced low level starts the frame; enter START.
  - START: wait DIV/2 clocks, then sample. If high, treat as a false start and return to IDLE. If low, enter DATA.
  - DATA: sample every DIV clocks, 8 bits, LSB first.
  - STOP: sample after DIV clocks.
    - If high: push the byte. If the RX FIFO is full, drop the byte and set overrun.
    - If low: discard the byte and set framing.
  - In either STOP case, return to IDLE once the line is seen high.
- Flag precedence: a set and a software clear in the same cycle leave the flag set.

Test Plan:
1. Bench params CLK_FREQ_HZ=1000000, BAUD_RATE=100000 (DIV=10). Write DATA 0x41 → TXD low 10 clks, then bits 1,0,0,0,0,0,1,0 at 10 clks each, then high 10 clks. Status bit10=1 afterwards.
2. Write 9 bytes 0x30..0x38 back-to-back (TX_DEPTH=8, first byte popped immediately) → status bit9=1 after the 9th write. All 9 frames are sent contiguously with no idle gaps. A 10th write while full is dropped.
3. Drive RXD frame 0x5A → 1 cycle after the stop bit, status bit8=1. Read DATA → mem_rdata=0x0000005A one cycle after rstrb, and bit8 returns to 0.
4. Send 9 RX frames without reading → 8 bytes are stored, overrun=1, and the 9th byte is lost. Write CNTL 0x800 → overrun=0.
5. Drive a frame with stop bit low → nothing pushed, framing=1. A 3-clock low glitch on RXD → false start, nothing pushed.
6. Assert reset during TX DATA and during an RX frame → TXD=1, mem_rdata=0, status=0x400 on the first post-reset read.
